if_id_latch: RTL and testbench

IF/ID pipeline boundary of the 5-stage core. Captures the fetched instruction word and its PC from the fetch stage, and pre-decodes the register fields for the decode stage. Detects load-use hazards against the instruction in ID/EX and drives the data-interlock signal back to fetch. Squashes its contents when a branch is taken.

---
 rtl/core_pkg.sv | 29 ++
 rtl/if_id_latch_hazard_unit.sv | 30 +++
 rtl/if_id_latch.sv | 100 ++++++++++
 tb/tb_if_id_latch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, bubble encoding, instruction field slices
// and the IF/ID FSM state type.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ifid_state_t;

endpackage

// File: rtl/if_id_latch_hazard_unit.sv
// Load-use hazard detection between the instruction in IF/ID and a load in ID/EX.
module hazard_unit
    import core_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic uses_rs1;
    logic uses_rs2;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        if (id_opcode == OPC_LUI || id_opcode == OPC_AUIPC || id_opcode == OPC_JAL)
            uses_rs1 = 1'b0;
        if (id_opcode == OPC_BRANCH || id_opcode == OPC_STORE || id_opcode == OPC_OP)
            uses_rs2 = 1'b1;
    end

    assign hazard = id_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));

endmodule

// File: rtl/if_id_latch.sv
// IF/ID pipeline register with load-use interlock and branch flush.
// Optional performance counters are enabled with `define IFID_PERF_CNT_EN.
module if_id_latch
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_WORD = core_pkg::NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_ir,
    input  logic [XLEN-1:0] if_pc,
    input  logic            branch_taken,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    output logic [XLEN-1:0] id_ir,
    output logic [XLEN-1:0] id_pc,
    output logic            id_valid,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
`ifdef IFID_PERF_CNT_EN
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count,
`endif
    output logic            data_interlock,
    output logic            id_bubble
);

    ifid_state_t state;
    logic        hazard;

    assign id_opcode = id_ir[OPC_MSB:OPC_LSB];
    assign id_rd     = id_ir[RD_MSB:RD_LSB];
    assign id_rs1    = id_ir[RS1_MSB:RS1_LSB];
    assign id_rs2    = id_ir[RS2_MSB:RS2_LSB];

    hazard_unit u_hazard (
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .hazard     (hazard)
    );

    // Only the first cycle of a hazard interlocks; in STALL, ID/EX already holds the bubble.
    assign data_interlock = hazard && (state == RUN);
    assign id_bubble      = data_interlock;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ir    <= NOP_WORD;
            id_pc    <= '0;
            id_valid <= 1'b0;
            state    <= RUN;
        end else if (branch_taken) begin
            id_ir    <= NOP_WORD;
            id_valid <= 1'b0;
            state    <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        state <= STALL;
                    end else begin
                        id_ir    <= if_ir;
                        id_pc    <= if_pc;
                        id_valid <= 1'b1;
                    end
                end
                STALL: begin
                    id_ir    <= if_ir;
                    id_pc    <= if_pc;
                    id_valid <= 1'b1;
                    state    <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (data_interlock && !branch_taken)
                stall_count <= stall_count + 32'd1;
            if (branch_taken)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_latch.sv
// Directed self-checking bench for if_id_latch (IFID_PERF_CNT_EN section runs when defined).
module tb_if_id_latch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic        branch_taken;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] id_ir;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        data_interlock;
    logic        id_bubble;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADD_X2   = 32'h0020_8133; // add x2,x1,x2
    localparam logic [31:0] ADD_X3   = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] ADD_X4   = 32'h0031_0233; // add x4,x2,x3
    localparam logic [31:0] LUI_X5   = 32'h0000_A2B7; // lui x5,0xA : rs1 bits = 1

    if_id_latch dut (
        .clk            (clk),
        .reset          (reset),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .branch_taken   (branch_taken),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .id_ir          (id_ir),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rd          (id_rd),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
`ifdef IFID_PERF_CNT_EN
        .stall_count    (stall_count),
        .flush_count    (flush_count),
`endif
        .data_interlock (data_interlock),
        .id_bubble      (id_bubble)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch side changes on the falling edge; sample 1 ns later.
    task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                         input logic br, input logic ld, input logic [4:0] rd);
        @(negedge clk);
        if_ir        = ir;
        if_pc        = pc;
        branch_taken = br;
        ex_is_load   = ld;
        ex_rd        = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_ir = '0; if_pc = '0; branch_taken = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
        #2;
        check("rst_ir", id_ir, NOP);
        check("rst_pc", id_pc, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_interlock", {31'b0, data_interlock}, 32'h0);
        check("rst_bubble", {31'b0, id_bubble}, 32'h0);
        check("rst_opcode", {25'b0, id_opcode}, 32'h13);
        check("rst_rd", {27'b0, id_rd}, 32'h0);
        #1 reset = 1'b0;

        // Normal flow
        drive(ADD_X2, 32'h10, 1'b0, 1'b0, 5'd0);
        check("norm_interlock", {31'b0, data_interlock}, 32'h0);
        tick();
        check("norm_rs1", {27'b0, id_rs1}, 32'd1);
        check("norm_rs2", {27'b0, id_rs2}, 32'd2);
        check("norm_rd", {27'b0, id_rd}, 32'd2);
        check("norm_pc", id_pc, 32'h10);
        check("norm_valid", {31'b0, id_valid}, 32'h1);
        check("norm_opcode", {25'b0, id_opcode}, 32'h33);

        // Load-use on rs2 of add x3,x1,x2
        drive(ADD_X3, 32'h14, 1'b0, 1'b0, 5'd0);
        tick();
        check("lu_setup_rd", {27'b0, id_rd}, 32'd3);
        drive(ADD_X4, 32'h18, 1'b0, 1'b1, 5'd2);
        check("lu_interlock", {31'b0, data_interlock}, 32'h1);
        check("lu_bubble", {31'b0, id_bubble}, 32'h1);
        tick();
        check("lu_hold_ir", id_ir, ADD_X3);
        check("lu_hold_pc", id_pc, 32'h14);
        check("lu_stall_interlock", {31'b0, data_interlock}, 32'h0);
        drive(ADD_X4, 32'h18, 1'b0, 1'b0, 5'd0);
        check("lu_c1_interlock", {31'b0, data_interlock}, 32'h0);
        tick();
        check("lu_capture_ir", id_ir, ADD_X4);
        check("lu_capture_pc", id_pc, 32'h18);

        // add x4,x2,x3 in ID: rs2 match, ex_rd=0, non-load
        drive(LUI_X5, 32'h1C, 1'b0, 1'b1, 5'd3);
        check("rs2_match", {31'b0, data_interlock}, 32'h1);
        ex_rd = 5'd0; #1;
        check("exrd0", {31'b0, data_interlock}, 32'h0);
        ex_rd = 5'd2; ex_is_load = 1'b0; #1;
        check("not_load", {31'b0, data_interlock}, 32'h0);
        tick();
        check("lui_captured", id_ir, LUI_X5);

        // LUI with ex_rd matching its rs1 bits
        drive(ADD_X4, 32'h20, 1'b0, 1'b1, 5'd1);
        check("lui_no_stall", {31'b0, data_interlock}, 32'h0);
        ex_is_load = 1'b0;
        tick();
        check("lui_next_ir", id_ir, ADD_X4);

        // Branch during hazard
        drive(ADD_X3, 32'h24, 1'b1, 1'b1, 5'd2);
        check("br_interlock_shown", {31'b0, data_interlock}, 32'h1);
        tick();
        check("br_valid", {31'b0, id_valid}, 32'h0);
        check("br_ir", id_ir, NOP);
        check("br_pc_held", id_pc, 32'h20);
        check("br_interlock_after", {31'b0, data_interlock}, 32'h0);
        drive(ADD_X3, 32'h24, 1'b0, 1'b1, 5'd2);
        check("bubble_no_hazard", {31'b0, data_interlock}, 32'h0);
        tick();
        check("br_run_capture", id_ir, ADD_X3);
        check("br_run_valid", {31'b0, id_valid}, 32'h1);

        // Reset mid-stall
        drive(ADD_X4, 32'h28, 1'b0, 1'b1, 5'd1);
        check("rs1_match", {31'b0, data_interlock}, 32'h1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ir", id_ir, NOP);
        check("mid_rst_valid", {31'b0, id_valid}, 32'h0);
        check("mid_rst_pc", id_pc, 32'h0);
        check("mid_rst_interlock", {31'b0, data_interlock}, 32'h0);
        reset = 1'b0;
        drive(ADD_X4, 32'h2C, 1'b0, 1'b0, 5'd0);
        tick();
        check("post_rst_ir", id_ir, ADD_X4);
        drive(ADD_X3, 32'h30, 1'b0, 1'b1, 5'd2);
        check("post_rst_run", {31'b0, data_interlock}, 32'h1);
        ex_is_load = 1'b0; #1;
        tick();
        check("post_rst_capture", id_ir, ADD_X3);

`ifdef IFID_PERF_CNT_EN
        reset = 1'b1; #1; reset = 1'b0;
        check("cnt_rst_stall", stall_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(ADD_X4, 32'h40, 1'b0, 1'b0, 5'd0);
            tick();
            drive(ADD_X4, 32'h40, 1'b0, 1'b1, 5'd2);
            tick();
            drive(ADD_X4, 32'h40, 1'b0, 1'b0, 5'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(ADD_X4, 32'h44, 1'b1, 1'b0, 5'd0);
            tick();
        end
        check("cnt_stall", stall_count, 32'd3);
        check("cnt_flush", flush_count, 32'd2);
        drive(ADD_X4, 32'h48, 1'b0, 1'b0, 5'd0);
        reset = 1'b1; #1;
        check("cnt_clr_stall", stall_count, 32'd0);
        check("cnt_clr_flush", flush_count, 32'd0);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
